// File: rtl/estop_multi.sv
// Multi-button emergency-stop controller: synchronises and debounces the e-stop contacts,
// latches the trip cause, and holds the SSR open for a minimum time until an explicit rearm.
module estop_multi #(
   parameter int unsigned N_BTN     = 2,
   parameter int unsigned DEB_LEN   = 8,
   parameter int unsigned OPEN_HOLD = 15
) (
   input  logic             clk_1m,
   input  logic             rst,
   input  logic [N_BTN-1:0] estop_btn_no,
   input  logic             estop_open,
   input  logic             estop_activation,
   input  logic             teensy_activation,
   input  logic             diag_activation,
   input  logic             rearm,
   output logic             ssr_enable,
   output logic             fault_latched,
   output logic [N_BTN:0]   trip_src,
   output logic [1:0]       state
);

   localparam int unsigned DEB_W  = $clog2(DEB_LEN + 1);
   localparam int unsigned HOLD_W = $clog2(OPEN_HOLD + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ACTIVE  = 2'b01,
      ST_TRIPPED = 2'b10,
      ST_LOCKED  = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [N_BTN:0]      sync1_q, sync2_q;
   logic [N_BTN:0]      trip_src_q, trip_src_d;
   logic [N_BTN-1:0]    btn_sync;
   logic [N_BTN-1:0]    btn_db;
   logic                open_sync;
   logic                trip;
   logic                act_req;
   logic                rearm_ok;

   // Two-flop synchronisers; idle level is "healthy" so reset never looks like a trip.
   always_ff @(posedge clk_1m) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= {estop_open, estop_btn_no};
         sync2_q <= sync1_q;
      end
   end

   assign btn_sync  = sync2_q[N_BTN-1:0];
   assign open_sync = sync2_q[N_BTN];

   // Per-button debounce: adopt the new level only after DEB_LEN consecutive disagreeing cycles.
   for (genvar g = 0; g < N_BTN; g++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             db_q, db_d;

      always_comb begin
         db_d  = db_q;
         cnt_d = '0;
         if (btn_sync[g] != db_q) begin
            if (cnt_q == DEB_W'(DEB_LEN - 1)) begin
               db_d = btn_sync[g];
            end else begin
               cnt_d = cnt_q + DEB_W'(1);
            end
         end
      end

      always_ff @(posedge clk_1m) begin
         if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
         end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
         end
      end

      assign btn_db[g] = db_q;
   end

   assign trip     = (~&btn_db) | ~open_sync;
   assign act_req  = estop_activation & teensy_activation;
   assign rearm_ok = (state_q == ST_LOCKED) & rearm & ~trip;

   // State and hold-counter register.
   always_ff @(posedge clk_1m) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next state; trip wins over every other transition and restarts the open-hold timer.
   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (trip) begin
               state_d = ST_TRIPPED;
            end else if (act_req) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (trip) begin
               state_d = ST_TRIPPED;
            end else if (!act_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_TRIPPED: begin
            if (!trip) begin
               if (hold_q == HOLD_W'(OPEN_HOLD - 1)) begin
                  state_d = ST_LOCKED;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         ST_LOCKED: begin
            if (trip) begin
               state_d = ST_TRIPPED;
            end else if (rearm) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky trip cause, cleared only by an accepted rearm.
   always_comb begin
      trip_src_d = trip_src_q;
      if (rearm_ok) begin
         trip_src_d = '0;
      end else if (trip) begin
         trip_src_d = trip_src_q | {~open_sync, ~btn_db};
      end
   end

   always_ff @(posedge clk_1m) begin
      if (rst) begin
         trip_src_q <= '0;
      end else begin
         trip_src_q <= trip_src_d;
      end
   end

   // Outputs; the diagnostic override reaches the SSR without waiting for a clock.
   always_comb begin
      ssr_enable    = diag_activation | (state_q == ST_ACTIVE);
      fault_latched = state_q[1];
      state         = state_q;
      trip_src      = trip_src_q;
   end

endmodule

// File: tb/tb_estop_multi.sv
// Directed bench for estop_multi at default parameters (N_BTN=2, DEB_LEN=8, OPEN_HOLD=15).
`timescale 1ns/1ps
module tb_estop_multi;

   logic       clk_1m = 1'b0;
   logic       rst;
   logic [1:0] estop_btn_no;
   logic       estop_open;
   logic       estop_activation;
   logic       teensy_activation;
   logic       diag_activation;
   logic       rearm;
   logic       ssr_enable;
   logic       fault_latched;
   logic [2:0] trip_src;
   logic [1:0] state;

   int n_checks = 0;
   int n_fails  = 0;

   always #500 clk_1m = ~clk_1m;

   estop_multi dut (
      .clk_1m           (clk_1m),
      .rst              (rst),
      .estop_btn_no     (estop_btn_no),
      .estop_open       (estop_open),
      .estop_activation (estop_activation),
      .teensy_activation(teensy_activation),
      .diag_activation  (diag_activation),
      .rearm            (rearm),
      .ssr_enable       (ssr_enable),
      .fault_latched    (fault_latched),
      .trip_src         (trip_src),
      .state            (state)
   );

   // One cycle = one rising edge, then settle before sampling/driving.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_1m);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic pulse_rearm();
      rearm = 1'b1;
      tick(1);
      rearm = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      estop_btn_no      = 2'b11;
      estop_open        = 1'b1;
      estop_activation  = 1'b1;
      teensy_activation = 1'b1;
      diag_activation   = 1'b0;
      rearm             = 1'b0;

      // Reset state
      tick(3);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ssr", 32'(ssr_enable), 32'd0);
      check("rst_fault", 32'(fault_latched), 32'd0);
      check("rst_src", 32'(trip_src), 32'd0);
      diag_activation = 1'b1;
      #1;
      check("rst_diag_ssr", 32'(ssr_enable), 32'd1);
      diag_activation = 1'b0;
      #1;

      // One IDLE cycle with both activations high, then ACTIVE
      rst = 1'b0;
      tick(1);
      check("close_state", 32'(state), 32'd1);
      check("close_ssr", 32'(ssr_enable), 32'd1);

      // Short glitch on btn0 is filtered
      estop_btn_no = 2'b10;
      tick(5);
      estop_btn_no = 2'b11;
      tick(12);
      check("glitch_state", 32'(state), 32'd1);
      check("glitch_ssr", 32'(ssr_enable), 32'd1);
      check("glitch_src", 32'(trip_src), 32'd0);

      // btn1 held: SSR opens exactly DEB_LEN+3 = 11 cycles later
      estop_btn_no = 2'b01;
      tick(10);
      check("btn1_lat10_ssr", 32'(ssr_enable), 32'd1);
      tick(1);
      check("btn1_lat11_ssr", 32'(ssr_enable), 32'd0);
      check("btn1_state", 32'(state), 32'd2);
      check("btn1_src", 32'(trip_src), 32'd2);
      check("btn1_fault", 32'(fault_latched), 32'd1);
      tick(5);
      check("btn1_held", 32'(state), 32'd2);
      // Release: debounce clears at edge 10, then 15 trip-free cycles to LOCKED
      estop_btn_no = 2'b11;
      tick(24);
      check("btn1_hold24", 32'(state), 32'd2);
      tick(1);
      check("btn1_locked", 32'(state), 32'd3);
      check("btn1_locked_src", 32'(trip_src), 32'd2);
      check("btn1_locked_ssr", 32'(ssr_enable), 32'd0);
      pulse_rearm();
      check("rearm1_state", 32'(state), 32'd0);
      check("rearm1_src", 32'(trip_src), 32'd0);
      check("rearm1_fault", 32'(fault_latched), 32'd0);
      tick(1);
      check("reclose1", 32'(state), 32'd1);

      // One-cycle estop_open pulse: TRIPPED after exactly 3 cycles
      estop_open = 1'b0;
      tick(1);
      estop_open = 1'b1;
      tick(1);
      check("open_lat2", 32'(state), 32'd1);
      tick(1);
      check("open_lat3", 32'(state), 32'd2);
      check("open_src", 32'(trip_src), 32'd4);
      tick(14);
      check("open_hold14", 32'(state), 32'd2);
      tick(1);
      check("open_locked", 32'(state), 32'd3);
      pulse_rearm();
      check("rearm2_state", 32'(state), 32'd0);
      check("rearm2_src", 32'(trip_src), 32'd0);
      tick(1);
      check("reclose2", 32'(state), 32'd1);

      // Reach LOCKED again, then press btn0: rearm coinciding with trip is ignored
      estop_open = 1'b0;
      tick(1);
      estop_open = 1'b1;
      tick(17);
      check("lock3", 32'(state), 32'd3);
      estop_btn_no = 2'b10;
      tick(10);
      check("lock3_pre_trip", 32'(state), 32'd3);
      pulse_rearm();
      check("rearm_tripping", 32'(state), 32'd2);
      check("rearm_tripping_src", 32'(trip_src), 32'd5);
      tick(2);
      pulse_rearm();
      check("rearm_tripped_btn", 32'(state), 32'd2);
      diag_activation = 1'b1;
      #1;
      check("diag_tripped", 32'(ssr_enable), 32'd1);
      diag_activation = 1'b0;
      #1;
      check("nodiag_tripped", 32'(ssr_enable), 32'd0);
      // Rearm during the open-hold window with trip already clear is also ignored
      estop_btn_no = 2'b11;
      tick(12);
      pulse_rearm();
      check("rearm_in_hold", 32'(state), 32'd2);
      check("rearm_in_hold_src", 32'(trip_src), 32'd5);
      tick(11);
      check("hold_after_rearm", 32'(state), 32'd2);
      tick(1);
      check("lock4", 32'(state), 32'd3);
      diag_activation = 1'b1;
      #1;
      check("diag_locked", 32'(ssr_enable), 32'd1);
      diag_activation = 1'b0;
      #1;

      // Rearm into IDLE with host request dropped; IDLE holds, diag still closes
      estop_activation = 1'b0;
      pulse_rearm();
      check("rearm3_state", 32'(state), 32'd0);
      check("rearm3_src", 32'(trip_src), 32'd0);
      tick(1);
      check("idle_stay", 32'(state), 32'd0);
      check("idle_ssr", 32'(ssr_enable), 32'd0);
      diag_activation = 1'b1;
      #1;
      check("diag_idle", 32'(ssr_enable), 32'd1);
      diag_activation = 1'b0;
      #1;
      estop_activation = 1'b1;
      tick(1);
      check("reclose3", 32'(state), 32'd1);
      teensy_activation = 1'b0;
      tick(1);
      check("teensy_drop", 32'(state), 32'd0);
      check("teensy_drop_ssr", 32'(ssr_enable), 32'd0);
      teensy_activation = 1'b1;
      tick(1);
      check("reclose4", 32'(state), 32'd1);

      // Reset in the middle of TRIPPED abandons the hold
      estop_open = 1'b0;
      tick(1);
      estop_open = 1'b1;
      tick(2);
      check("trip5", 32'(state), 32'd2);
      tick(4);
      rst = 1'b1;
      tick(1);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_src", 32'(trip_src), 32'd0);
      check("midrst_fault", 32'(fault_latched), 32'd0);
      rst = 1'b0;
      tick(1);
      check("postrst_close", 32'(state), 32'd1);
      // Fresh trip after reset still needs the full 15-cycle hold
      estop_open = 1'b0;
      tick(1);
      estop_open = 1'b1;
      tick(16);
      check("postrst_hold", 32'(state), 32'd2);
      tick(1);
      check("postrst_locked", 32'(state), 32'd3);
      check("postrst_src", 32'(trip_src), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/estop_multi.md
ESTOP_MULTI -- requirements
Module: estop_multi

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of normally-closed e-stop buttons (1..8).
REQ-002 SHALL have parameter DEB_LEN, default 8, debounce stability length in clk_1m cycles (1..255).
REQ-003 SHALL have parameter OPEN_HOLD, default 15, minimum SSR-open time in clk_1m cycles after a trip (1..65535).
REQ-004 clk_1m  input  1  single 1 MHz system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 estop_btn_no  input  N_BTN  button contacts; 1 = healthy, 0 = pressed; asynchronous.
REQ-007 estop_open  input  1  external open request; 0 = open SSR; asynchronous.
REQ-008 estop_activation  input  1  host close request, level.
REQ-009 teensy_activation  input  1  Teensy close permission, level.
REQ-010 diag_activation  input  1  diagnostic override; forces ssr_enable high.
REQ-011 rearm  input  1  single-cycle re-arm pulse after a trip.
REQ-012 ssr_enable  output  1  SSR drive; 1 = closed.
REQ-013 fault_latched  output  1  high in TRIPPED or LOCKED.
REQ-014 trip_src  output  N_BTN+1  sticky trip cause; bit i = button i, bit N_BTN = estop_open.
REQ-015 state  output  2  FSM state code.

Function
REQ-016 Each estop_btn_no bit and estop_open SHALL pass through a 2-flop synchroniser reset to 1.
REQ-017 Each synchronised button SHALL have a debounce counter; debounced value adopts the synchronised value only after it differs from the debounced value for DEB_LEN consecutive cycles; any agreeing cycle clears the counter.
REQ-018 estop_open SHALL be synchronised only, not debounced.
REQ-019 trip SHALL be 1 when any debounced button is 0 or synchronised estop_open is 0.
REQ-020 FSM states: IDLE=2'b00, ACTIVE=2'b01, TRIPPED=2'b10, LOCKED=2'b11.
REQ-021 IDLE: trip -> TRIPPED; else estop_activation & teensy_activation -> ACTIVE; else stay.
REQ-022 ACTIVE: trip -> TRIPPED; else !(estop_activation & teensy_activation) -> IDLE; else stay.
REQ-023 TRIPPED: hold counter increments each cycle; trip asserted restarts counter at 0; counter reaching OPEN_HOLD-1 with trip low -> LOCKED.
REQ-024 LOCKED: rearm=1 and trip=0 -> IDLE; rearm while trip=1 ignored; trip=1 -> TRIPPED (counter 0).
REQ-025 Trip SHALL take priority over every other transition in every state.
REQ-026 Hold counter width SHALL be $clog2(OPEN_HOLD+1); it SHALL never wrap.
REQ-027 On every cycle trip=1, trip_src SHALL OR in {~open_sync, ~btn_db}; cleared only on accepted rearm or reset.
REQ-028 ssr_enable SHALL equal diag_activation OR (state==ACTIVE); no other path closes the SSR.
REQ-029 fault_latched SHALL equal state[1].
REQ-030 Latency button pin low -> state leaves ACTIVE: exactly DEB_LEN+3 cycles; estop_open low -> TRIPPED: exactly 3 cycles.
REQ-031 Activation inputs SHALL be used unsynchronised (same-domain host signals); IDLE->ACTIVE one cycle after both high.

Reset
REQ-032 rst SHALL set: state IDLE, synchronisers and debounced values 1, debounce and hold counters 0, trip_src 0.
REQ-033 During/after reset ssr_enable SHALL equal diag_activation; rst mid-TRIPPED SHALL abandon hold and return to IDLE.
REQ-034 After reset, closing requires one cycle in IDLE with trip=0 and both activations high.

Verification (defaults N_BTN=2, DEB_LEN=8, OPEN_HOLD=15)
REQ-035 Reset, buttons 1, open 1, both activations high -> state 01, ssr_enable=1 on 2nd cycle after rst release.
REQ-036 In ACTIVE, btn0 low for 5 cycles then high -> no trip, ssr_enable stays 1, trip_src=0.
REQ-037 In ACTIVE, btn1 held low -> ssr_enable=0 exactly 11 cycles later, trip_src=3'b010, fault_latched=1; release -> LOCKED after debounce+15 cycles.
REQ-038 estop_open pulsed low 1 cycle in ACTIVE -> TRIPPED 3 cycles later, LOCKED 15 cycles after trip clears, trip_src=3'b100; rearm -> IDLE, trip_src=0, then ACTIVE.
REQ-039 rearm in LOCKED while btn0 still low -> ignored; rearm in TRIPPED -> ignored; diag_activation=1 in any state -> ssr_enable=1.
REQ-040 rst asserted mid-TRIPPED -> next cycle state 00, trip_src 0, counters 0.
